// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        RESYNC = 3'd4
    } rx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Valid/ready word port of the serial frame receiver, with per-word error flags.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              parity_err;
  logic              frame_err;

  modport master (
    output out_data,
    output out_valid,
    output parity_err,
    output frame_err,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  parity_err,
    input  frame_err,
    output out_ready
  );
endinterface

// File: rtl/rx_out_slot.sv
// Single-entry valid/ready holding register; a completion arriving while the
// held word is not being accepted is dropped and flagged with an overrun pulse.
module rx_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              parity_err_i,
  input  logic              frame_err_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              slot_free;

  // An accept in the same cycle frees the slot for the incoming word.
  assign slot_free = !valid_q || ready_i;

  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (load_req_i && slot_free) begin
      data_d       = data_i;
      valid_d      = 1'b1;
      parity_err_d = parity_err_i;
      frame_err_d  = frame_err_i;
    end else begin
      if (valid_q && ready_i) valid_d = 1'b0;
      if (load_req_i)         overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, MSB-first payload, optional even parity,
// stop bit; completed words are handed to a single-entry output slot.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    si,
  input  logic                    si_en,
  serial_frame_rx_if.master       out_if,
  output logic                    overrun,
  output logic                    busy
);
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              busy_q;
  logic              complete;
  logic              parity_ok;
  logic              stop_bad;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    complete = 1'b0;
    if (si_en) begin
      unique case (state_q)
        IDLE: begin
          if (si == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {shreg_q[DATA_W-2:0], si};
          if (cnt_q == CNT_LAST) state_d = PARITY_EN ? PARITY : STOP;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        PARITY: begin
          par_d   = si;
          state_d = STOP;
        end
        STOP: begin
          complete = 1'b1;
          state_d  = (si == STOP_BIT) ? IDLE : RESYNC;
        end
        RESYNC: begin
          // A low stop bit must not be mistaken for the next start bit.
          if (si == IDLE_LEVEL) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign parity_ok = PARITY_EN ? !(^{shreg_q, par_q}) : 1'b1;
  assign stop_bad  = (si != STOP_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  rx_out_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk          (clk),
    .rst          (rst),
    .load_req_i   (complete),
    .data_i       (shreg_q),
    .parity_err_i (!parity_ok),
    .frame_err_i  (stop_bad),
    .ready_i      (out_if.out_ready),
    .data_o       (out_if.out_data),
    .valid_o      (out_if.out_valid),
    .parity_err_o (out_if.parity_err),
    .frame_err_o  (out_if.frame_err),
    .overrun_o    (overrun)
  );

  assign busy = busy_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8, even parity enabled).
module tb_serial_frame_rx;
  import serial_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic si;
  logic si_en;
  logic overrun;
  logic busy;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;

  serial_frame_rx_if #(.DATA_W(8)) rx_if ();

  serial_frame_rx #(
    .DATA_W    (8),
    .PARITY_EN (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .si      (si),
    .si_en   (si_en),
    .out_if  (rx_if),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic en);
    si    = b;
    si_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit slow, inout logic pre_valid, inout logic busy_all);
    step(b, 1'b1);
    pre_valid = pre_valid | rx_if.out_valid;
    busy_all  = busy_all & busy;
    if (slow) begin
      step(~b, 1'b0);
      pre_valid = pre_valid | rx_if.out_valid;
      busy_all  = busy_all & busy;
    end
  endtask

  // Sends start, payload MSB-first and parity; returns just after the stop-bit edge.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input bit slow, input logic rdy_stop,
                            output logic pre_valid, output logic busy_all);
    logic saved_rdy;
    pre_valid = 1'b0;
    busy_all  = 1'b1;
    send_bit(START_BIT, slow, pre_valid, busy_all);
    for (int i = 7; i >= 0; i--) send_bit(data[i], slow, pre_valid, busy_all);
    send_bit(par, slow, pre_valid, busy_all);
    saved_rdy       = rx_if.out_ready;
    rx_if.out_ready = rdy_stop;
    step(stop, 1'b1);
    rx_if.out_ready = saved_rdy;
    $display("frame data=0x%02h par=%0b stop=%0b slow=%0b -> out_valid=%0b out_data=0x%02h perr=%0b ferr=%0b ovr=%0b",
             data, par, stop, slow, rx_if.out_valid, rx_if.out_data, rx_if.parity_err, rx_if.frame_err, overrun);
  endtask

  initial begin
    logic pv, ba, any_v, all_b;
    int   ov0;

    rst = 1'b1; si = 1'b1; si_en = 1'b0; rx_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",    rx_if.out_data,   32'h0);
    check("rst_valid",   rx_if.out_valid,  32'h0);
    check("rst_perr",    rx_if.parity_err, 32'h0);
    check("rst_ferr",    rx_if.frame_err,  32'h0);
    check("rst_overrun", overrun,          32'h0);
    check("rst_busy",    busy,             32'h0);
    rst = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Good frame: nothing valid before the stop edge, valid right after it, for one cycle.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, pv, ba);
    check("good_early_valid", pv, 32'h0);
    check("good_busy",        ba, 32'h1);
    check("good_valid",       rx_if.out_valid,  32'h1);
    check("good_data",        rx_if.out_data,   32'hA5);
    check("good_perr",        rx_if.parity_err, 32'h0);
    check("good_ferr",        rx_if.frame_err,  32'h0);
    check("good_idle_busy",   busy,             32'h0);
    step(1'b1, 1'b1);
    check("good_one_cycle",   rx_if.out_valid,  32'h0);
    check("good_data_kept",   rx_if.out_data,   32'hA5);

    // Parity error: 0x01 needs parity 1 for even parity.
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, pv, ba);
    check("perr_valid", rx_if.out_valid,  32'h1);
    check("perr_data",  rx_if.out_data,   32'h01);
    check("perr_perr",  rx_if.parity_err, 32'h1);
    check("perr_ferr",  rx_if.frame_err,  32'h0);
    step(1'b1, 1'b1);

    // Framing error, then a held-low line must keep the receiver in resync.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, pv, ba);
    check("ferr_valid", rx_if.out_valid,  32'h1);
    check("ferr_data",  rx_if.out_data,   32'h3C);
    check("ferr_ferr",  rx_if.frame_err,  32'h1);
    check("ferr_perr",  rx_if.parity_err, 32'h0);
    check("ferr_busy",  busy,             32'h1);
    any_v = 1'b0; all_b = 1'b1;
    repeat (5) begin
      step(1'b0, 1'b1);
      any_v = any_v | rx_if.out_valid;
      all_b = all_b & busy;
    end
    check("resync_no_valid", any_v, 32'h0);
    check("resync_busy",     all_b, 32'h1);
    step(1'b1, 1'b1);
    check("resync_exit_busy", busy, 32'h0);
    any_v = 1'b0;
    repeat (4) begin
      step(1'b1, 1'b1);
      any_v = any_v | rx_if.out_valid | busy;
    end
    check("resync_no_spurious", any_v, 32'h0);

    // Backpressure: second frame is dropped with a single overrun pulse.
    rx_if.out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, pv, ba);
    check("bp_first_valid", rx_if.out_valid, 32'h1);
    check("bp_first_data",  rx_if.out_data,  32'h11);
    step(1'b1, 1'b1);
    ov0 = ov_cnt;
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, pv, ba);
    check("bp_overrun",    overrun,         32'h1);
    check("bp_held_data",  rx_if.out_data,  32'h11);
    check("bp_held_valid", rx_if.out_valid, 32'h1);
    step(1'b1, 1'b1);
    check("bp_overrun_pulse", overrun,      32'h0);
    check("bp_overrun_count", ov_cnt - ov0, 32'h1);
    rx_if.out_ready = 1'b1;
    step(1'b1, 1'b1);
    check("bp_drain_valid", rx_if.out_valid, 32'h0);
    check("bp_drain_data",  rx_if.out_data,  32'h11);

    // Accept coinciding with completion: new word loads, no overrun.
    rx_if.out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, pv, ba);
    step(1'b1, 1'b1);
    ov0 = ov_cnt;
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, pv, ba);
    check("sim_data",    rx_if.out_data,  32'h22);
    check("sim_valid",   rx_if.out_valid, 32'h1);
    check("sim_overrun", overrun,         32'h0);
    step(1'b1, 1'b1);
    check("sim_still_valid", rx_if.out_valid, 32'h1);
    check("sim_no_overrun",  ov_cnt - ov0,    32'h0);
    rx_if.out_ready = 1'b1;
    step(1'b1, 1'b1);
    check("sim_drain", rx_if.out_valid, 32'h0);

    // Strobe every other cycle; gated cycles carry inverted junk on si.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, pv, ba);
    check("slow_early_valid", pv, 32'h0);
    check("slow_busy",        ba, 32'h1);
    check("slow_valid",       rx_if.out_valid,  32'h1);
    check("slow_data",        rx_if.out_data,   32'hA5);
    check("slow_perr",        rx_if.parity_err, 32'h0);
    step(1'b1, 1'b0);
    check("slow_accept_no_en", rx_if.out_valid, 32'h0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, pv, ba);
    check("slow_par_data", rx_if.out_data,   32'h01);
    check("slow_par_perr", rx_if.parity_err, 32'h0);
    step(1'b1, 1'b1);

    // Asynchronous reset mid-frame while a word is held.
    rx_if.out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, pv, ba);
    check("arst_pre_valid", rx_if.out_valid, 32'h1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("arst_pre_busy", busy, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_data",    rx_if.out_data,   32'h0);
    check("arst_valid",   rx_if.out_valid,  32'h0);
    check("arst_perr",    rx_if.parity_err, 32'h0);
    check("arst_ferr",    rx_if.frame_err,  32'h0);
    check("arst_overrun", overrun,          32'h0);
    check("arst_busy",    busy,             32'h0);
    #2 rst = 1'b0;
    rx_if.out_ready = 1'b1;
    step(1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, pv, ba);
    check("after_rst_valid", rx_if.out_valid,  32'h1);
    check("after_rst_data",  rx_if.out_data,   32'h5A);
    check("after_rst_perr",  rx_if.parity_err, 32'h0);
    check("after_rst_ferr",  rx_if.frame_err,  32'h0);
    step(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
